// File: rtl/puf_seq_ctrl.sv
// puf_seq_ctrl: RO PUF sequencer (seed, measurement windows, capture, challenge advance); define PUF_REPEAT_EN for per-bit repeated measurements
module puf_seq_ctrl #(
    parameter int RESP_BITS = 256,
    parameter int WINDOW    = 256,
    parameter int REPEATS   = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    output logic                         lfsr_dv,
    output logic                         lfsr_en,
    output logic                         ro_en,
    output logic                         count_en,
    output logic                         ref_en,
    output logic                         count_rst,
    output logic                         sr_en,
    output logic                         vote_en,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(RESP_BITS)-1:0] bit_idx
);
    localparam int BW = $clog2(RESP_BITS);
    localparam int WW = $clog2(WINDOW);

    if (RESP_BITS < 2 || WINDOW < 2 || REPEATS < 1 || REPEATS % 2 == 0) begin : g_param_check
        $error("puf_seq_ctrl: invalid RESP_BITS/WINDOW/REPEATS");
    end

`ifdef PUF_REPEAT_EN
    localparam int RW = (REPEATS > 1) ? $clog2(REPEATS) : 1;
    typedef enum logic [2:0] {IDLE, SEED, MEASURE, CAPTURE, ADVANCE, DONE, REARM} state_t;
    logic [RW-1:0] rep_idx;
`else
    typedef enum logic [2:0] {IDLE, SEED, MEASURE, CAPTURE, ADVANCE, DONE} state_t;
`endif

    state_t        state, nxt, win_end;
    logic [WW-1:0] win_cnt;

    // state register and loop counters; counters only ever clear explicitly, never wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            win_cnt <= '0;
            bit_idx <= '0;
`ifdef PUF_REPEAT_EN
            rep_idx <= '0;
`endif
        end else begin
            state   <= nxt;
            win_cnt <= (state == MEASURE && nxt == MEASURE) ? win_cnt + 1'b1 : '0;
            bit_idx <= (state == IDLE || nxt == IDLE) ? '0 :
                       (state == ADVANCE && nxt == MEASURE) ? bit_idx + 1'b1 : bit_idx;
`ifdef PUF_REPEAT_EN
            rep_idx <= (nxt == IDLE || state == CAPTURE) ? '0 :
                       (state == REARM) ? rep_idx + 1'b1 : rep_idx;
`endif
        end
    end

    // next state; abort from any busy state overrides every other transition
    always_comb begin
`ifdef PUF_REPEAT_EN
        win_end = (rep_idx == RW'(REPEATS - 1)) ? CAPTURE : REARM;
`else
        win_end = CAPTURE;
`endif
        nxt = state;
        if (abort && busy)
            nxt = IDLE;
        else
            case (state)
                IDLE:    nxt = start ? SEED : IDLE;
                SEED:    nxt = MEASURE;
                MEASURE: nxt = (win_cnt == WW'(WINDOW - 1)) ? win_end : MEASURE;
                CAPTURE: nxt = ADVANCE;
                ADVANCE: nxt = (bit_idx == BW'(RESP_BITS - 1)) ? DONE : MEASURE;
                DONE:    nxt = start ? DONE : IDLE;
`ifdef PUF_REPEAT_EN
                REARM:   nxt = MEASURE;
`endif
                default: nxt = IDLE;
            endcase
    end

    // outputs decoded purely from the registered state
    always_comb begin
        lfsr_dv   = state == SEED;
        lfsr_en   = state == SEED || state == CAPTURE;
        ro_en     = state == MEASURE;
        ref_en    = state == MEASURE;
        count_en  = state == MEASURE || state == CAPTURE || state == ADVANCE;
        sr_en     = state == CAPTURE;
        done      = state == DONE;
        busy      = state != IDLE && state != DONE;
`ifdef PUF_REPEAT_EN
        count_rst = state == IDLE || state == SEED || state == ADVANCE || state == REARM;
        vote_en   = state == CAPTURE || state == REARM;
`else
        count_rst = state == IDLE || state == SEED || state == ADVANCE;
        vote_en   = 1'b0;
`endif
    end
endmodule
